sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter PRIORITY_MODE, default 0, meaning 0 = round-robin between ports, 1 = fixed priority with port 0 always winning.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 p0_w_en / p0_r_en  input  1 each  port 0 write / read request, level, held until p0_ready.
REQ-005 p0_addr  input  32  port 0 byte address.
REQ-006 p0_wdata  input  32  port 0 write data.
REQ-007 p0_rdata  output  32  port 0 read data, registered, valid when p0_ready=1, held until next port-0 read completes.
REQ-008 p0_ready  output  1  one-cycle completion pulse for port 0.
REQ-009 p1_w_en, p1_r_en, p1_addr, p1_wdata, p1_rdata, p1_ready: identical to REQ-004..008 for port 1.
REQ-010 mem_w_en / mem_r_en  output  1 each  request to the SRAM controller.
REQ-011 mem_addr / mem_wdata  output  32 each  latched address / write data to the SRAM controller.
REQ-012 mem_rdata  input  32  SRAM controller read data, valid while mem_ready=1.
REQ-013 mem_ready  input  1  SRAM controller completion pulse.
REQ-014 busy  output  1  high in BUSY and DONE states.
REQ-015 grant_id  output  1  port owning the current or last transaction.

Function
REQ-016 FSM states SHALL be IDLE, BUSY, DONE; all outputs are driven from registers.
REQ-017 IDLE: if neither port requests, SHALL stay IDLE; otherwise SHALL select a winner and go to BUSY at the next edge.
REQ-018 Round-robin mode: if both ports request, the winner SHALL be the port not equal to grant_id; a single requester SHALL always win.
REQ-019 Fixed mode: port 0 SHALL win whenever p0 requests.
REQ-020 On IDLE->BUSY the arbiter SHALL latch winner address, write data and operation, and update grant_id; later changes on port inputs SHALL NOT affect mem_* outputs.
REQ-021 If a port asserts w_en and r_en together, the operation SHALL be a write.
REQ-022 BUSY: exactly one of mem_w_en/mem_r_en SHALL be high, held constant until mem_ready is sampled high.
REQ-023 On mem_ready in BUSY: next state DONE; for reads, winner's pN_rdata SHALL load mem_rdata at that edge; the other port's rdata SHALL be unchanged.
REQ-024 DONE: mem_w_en=mem_r_en=0; winner's pN_ready=1 for exactly this cycle; next state IDLE unconditionally.
REQ-025 The losing port's pN_ready SHALL stay 0; its request SHALL remain pending without loss.
REQ-026 mem_ready outside BUSY SHALL be ignored.
REQ-027 Minimum occupancy per transaction SHALL be IDLE(1)+BUSY(>=1)+DONE(1); mem enables SHALL be low for at least two cycles between transactions so the SRAM controller returns to its idle state before re-sampling.
REQ-028 A request still asserted in the IDLE after DONE SHALL be treated as a new transaction.

Reset
REQ-029 On rst: state IDLE; mem_w_en, mem_r_en, p0_ready, p1_ready, busy = 0; mem_addr, mem_wdata, p0_rdata, p1_rdata = 0; grant_id = 1, so port 0 wins the first contended round-robin arbitration.
REQ-030 rst asserted in BUSY or DONE SHALL abort the transaction with no pN_ready pulse and no rdata update; the SRAM controller shares rst.

Verification
REQ-031 Single read: p0_r_en, p0_addr=0x0000_0010; memory model returns 0xDEAD_BEEF after 5 cycles -> mem_r_en high for 5 cycles, mem_addr=0x10, then p0_ready pulses once with p0_rdata=0xDEAD_BEEF.
REQ-032 Contention, round-robin: p0 and p1 both write continuously from reset -> grant order 0,1,0,1; each ready pulse matches grant_id; mem_wdata matches the granted port.
REQ-033 Fixed mode: PRIORITY_MODE=1 with both ports requesting continuously -> only port 0 is granted and p1_ready stays 0.
REQ-034 Latch check: p1 read at 0x40 granted, then p1_addr changed to 0x80 mid-BUSY -> mem_addr stays 0x40 until DONE.
REQ-035 Reset mid-BUSY: rst for one cycle during a p0 write -> next cycle IDLE, all enables 0, no p0_ready pulse, grant_id=1.
REQ-036 w_en and r_en both high on p0 -> mem_w_en=1, mem_r_en=0; a spurious mem_ready in IDLE produces no ready pulse.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single SRAM controller.
// Round-robin or fixed-priority selection; every output comes straight from a register.
module sram_arbiter #(
    parameter int unsigned PRIORITY_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_w_en,
    input  logic        p0_r_en,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic [31:0] p0_rdata,
    output logic        p0_ready,
    input  logic        p1_w_en,
    input  logic        p1_r_en,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic [31:0] p1_rdata,
    output logic        p1_ready,
    output logic        mem_w_en,
    output logic        mem_r_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic        mem_w_en_q, mem_w_en_d;
    logic        mem_r_en_q, mem_r_en_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] p0_rdata_q, p0_rdata_d;
    logic [31:0] p1_rdata_q, p1_rdata_d;
    logic        p0_ready_q, p0_ready_d;
    logic        p1_ready_q, p1_ready_d;
    logic        busy_q, busy_d;
    logic        grant_q, grant_d;
    logic        req0, req1, win;

    assign req0 = p0_w_en | p0_r_en;
    assign req1 = p1_w_en | p1_r_en;

    // Only meaningful while at least one port requests.
    always_comb begin
        if (PRIORITY_MODE == 1) begin
            win = ~req0;
        end else if (req0 && req1) begin
            win = ~grant_q;
        end else begin
            win = ~req0;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_w_en_d  = mem_w_en_q;
        mem_r_en_d  = mem_r_en_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        p0_ready_d  = 1'b0;
        p1_ready_d  = 1'b0;
        busy_d      = busy_q;
        grant_d     = grant_q;
        case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d = StBusy;
                    busy_d  = 1'b1;
                    grant_d = win;
                    // Write takes precedence when both enables are set.
                    if (win) begin
                        mem_w_en_d  = p1_w_en;
                        mem_r_en_d  = ~p1_w_en;
                        mem_addr_d  = p1_addr;
                        mem_wdata_d = p1_wdata;
                    end else begin
                        mem_w_en_d  = p0_w_en;
                        mem_r_en_d  = ~p0_w_en;
                        mem_addr_d  = p0_addr;
                        mem_wdata_d = p0_wdata;
                    end
                end
            end
            StBusy: begin
                if (mem_ready) begin
                    state_d    = StDone;
                    mem_w_en_d = 1'b0;
                    mem_r_en_d = 1'b0;
                    if (grant_q) begin
                        p1_ready_d = 1'b1;
                        if (mem_r_en_q) p1_rdata_d = mem_rdata;
                    end else begin
                        p0_ready_d = 1'b1;
                        if (mem_r_en_q) p0_rdata_d = mem_rdata;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mem_w_en_q  <= 1'b0;
            mem_r_en_q  <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            p0_rdata_q  <= 32'h0;
            p1_rdata_q  <= 32'h0;
            p0_ready_q  <= 1'b0;
            p1_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            grant_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            mem_w_en_q  <= mem_w_en_d;
            mem_r_en_q  <= mem_r_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            p0_ready_q  <= p0_ready_d;
            p1_ready_q  <= p1_ready_d;
            busy_q      <= busy_d;
            grant_q     <= grant_d;
        end
    end

    assign mem_w_en  = mem_w_en_q;
    assign mem_r_en  = mem_r_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign p0_ready  = p0_ready_q;
    assign p1_ready  = p1_ready_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  w_en, r_en;
    logic [31:0] addr[2], wdata[2];
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        p0_ready, p1_ready, mem_w_en, mem_r_en, mem_ready, busy, grant_id;

    logic [1:0]  f_w_en, f_r_en;
    logic [31:0] f_addr[2], f_wdata[2];
    logic [31:0] f_p0_rdata, f_p1_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;
    logic        f_p0_ready, f_p1_ready, f_mem_w_en, f_mem_r_en, f_mem_ready, f_busy, f_grant_id;

    sram_arbiter #(.PRIORITY_MODE(0)) u_rr (
        .clk(clk), .rst(rst),
        .p0_w_en(w_en[0]), .p0_r_en(r_en[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
        .p0_rdata(p0_rdata), .p0_ready(p0_ready),
        .p1_w_en(w_en[1]), .p1_r_en(r_en[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
        .p1_rdata(p1_rdata), .p1_ready(p1_ready),
        .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .grant_id(grant_id)
    );

    sram_arbiter #(.PRIORITY_MODE(1)) u_fix (
        .clk(clk), .rst(rst),
        .p0_w_en(f_w_en[0]), .p0_r_en(f_r_en[0]), .p0_addr(f_addr[0]), .p0_wdata(f_wdata[0]),
        .p0_rdata(f_p0_rdata), .p0_ready(f_p0_ready),
        .p1_w_en(f_w_en[1]), .p1_r_en(f_r_en[1]), .p1_addr(f_addr[1]), .p1_wdata(f_wdata[1]),
        .p1_rdata(f_p1_rdata), .p1_ready(f_p1_ready),
        .mem_w_en(f_mem_w_en), .mem_r_en(f_mem_r_en), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata), .mem_ready(f_mem_ready),
        .busy(f_busy), .grant_id(f_grant_id)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, phase 0 waiting, 1 at memory, 2 completing.
    int          m_phase;
    logic        m_grant, m_w, m_r;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata[2];
    logic [1:0]  m_ready;

    task automatic model_step();
        logic q0, q1, win;
        q0 = w_en[0] | r_en[0];
        q1 = w_en[1] | r_en[1];
        if (rst) begin
            m_phase = 0; m_grant = 1'b1; m_w = 1'b0; m_r = 1'b0;
            m_addr = 0; m_wdata = 0; m_rdata[0] = 0; m_rdata[1] = 0; m_ready = 2'b00;
        end else if (m_phase == 0) begin
            m_ready = 2'b00;
            if (q0 || q1) begin
                if (q0 && q1) win = ~m_grant;
                else          win = q1;
                m_grant = win;
                m_w     = w_en[win];
                m_r     = ~w_en[win];
                m_addr  = addr[win];
                m_wdata = wdata[win];
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (mem_ready) begin
                if (m_r) m_rdata[m_grant] = mem_rdata;
                m_ready[m_grant] = 1'b1;
                m_w = 1'b0;
                m_r = 1'b0;
                m_phase = 2;
            end
        end else begin
            m_ready = 2'b00;
            m_phase = 0;
        end
    endtask

    task automatic compare_all();
        check("mem_w_en", 32'(mem_w_en), 32'(m_w));
        check("mem_r_en", 32'(mem_r_en), 32'(m_r));
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
        check("p0_rdata", p0_rdata, m_rdata[0]);
        check("p1_rdata", p1_rdata, m_rdata[1]);
        check("p0_ready", 32'(p0_ready), 32'(m_ready[0]));
        check("p1_ready", 32'(p1_ready), 32'(m_ready[1]));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("grant_id", 32'(grant_id), 32'(m_grant));
    endtask

    // SRAM controller stand-in.
    int          resp_cnt = 0;
    int          resp_target = 1;
    int          fix_lat = 0;
    int          spur_pct = 0;
    bit          use_fix_data = 1'b0;
    logic [31:0] fix_data = 32'h0;

    task automatic respond();
        if (mem_w_en || mem_r_en) begin
            resp_cnt++;
            if (resp_cnt == 1) resp_target = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 6));
            mem_ready = (resp_cnt >= resp_target);
            mem_rdata = use_fix_data ? fix_data : $urandom;
        end else begin
            resp_cnt  = 0;
            mem_ready = (int'($urandom_range(0, 99)) < spur_pct);
            mem_rdata = $urandom;
        end
        f_mem_ready = f_mem_w_en | f_mem_r_en;
        f_mem_rdata = 32'h0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        respond();
    endtask

    bit pend[2];

    task automatic start_req(input int p);
        logic w;
        w = 1'($urandom_range(0, 1));
        w_en[p]  = w;
        r_en[p]  = w ? 1'($urandom_range(0, 1)) : 1'b1;
        addr[p]  = $urandom;
        wdata[p] = $urandom;
        pend[p]  = 1'b1;
    endtask

    initial begin
        int          hi, pulses, n, cnt0, cnt1;
        int          seq[4];
        bit          seen;
        logic [31:0] got;
        logic        rdy;

        rst = 1'b1;
        w_en = 2'b00; r_en = 2'b00; f_w_en = 2'b00; f_r_en = 2'b00;
        for (int p = 0; p < 2; p++) begin
            addr[p] = 0; wdata[p] = 0; f_addr[p] = 0; f_wdata[p] = 0; pend[p] = 1'b0;
        end
        mem_ready = 1'b0; mem_rdata = 0; f_mem_ready = 1'b0; f_mem_rdata = 0;
        repeat (2) cycle();
        check("rst_grant_id", 32'(grant_id), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;

        // Single read with a 5-cycle memory.
        fix_lat = 5; use_fix_data = 1'b1; fix_data = 32'hDEAD_BEEF;
        r_en[0] = 1'b1; addr[0] = 32'h10;
        hi = 0; pulses = 0; got = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (mem_r_en && mem_addr == 32'h10) hi++;
            if (p0_ready) begin
                pulses++;
                got = p0_rdata;
                r_en[0] = 1'b0;
            end
        end
        check("rd_en_cycles", 32'(hi), 32'd5);
        check("rd_pulses", 32'(pulses), 32'd1);
        check("rd_data", got, 32'hDEAD_BEEF);
        check("rd_p1_rdata_kept", p1_rdata, 32'h0);

        // Spurious mem_ready while idle, then a write+read request.
        spur_pct = 100; cnt0 = 0;
        repeat (3) begin
            cycle();
            if (p0_ready || p1_ready) cnt0++;
        end
        check("spur_ready", 32'(cnt0), 32'd0);
        spur_pct = 0; fix_lat = 2;
        w_en[0] = 1'b1; r_en[0] = 1'b1; addr[0] = 32'h24; wdata[0] = 32'h1234_5678;
        cycle();
        check("wr_both_w", 32'(mem_w_en), 32'd1);
        check("wr_both_r", 32'(mem_r_en), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (p0_ready) begin seen = 1'b1; w_en[0] = 1'b0; r_en[0] = 1'b0; end
        end
        check("wr_both_done", 32'(seen), 32'd1);

        // Contention from reset: grants must alternate starting at port 0.
        rst = 1'b1; cycle(); rst = 1'b0;
        fix_lat = 0; use_fix_data = 1'b0;
        w_en = 2'b11; wdata[0] = 32'hA0A0_A0A0; wdata[1] = 32'hB1B1_B1B1;
        addr[0] = 32'h100; addr[1] = 32'h200;
        n = 0;
        for (int i = 0; i < 80 && n < 4; i++) begin
            cycle();
            if (p0_ready || p1_ready) begin
                seq[n] = int'(grant_id);
                check("ready_vs_grant", {30'd0, p1_ready, p0_ready}, grant_id ? 32'd2 : 32'd1);
                n++;
            end
        end
        w_en = 2'b00;
        check("rr_count", 32'(n), 32'd4);
        check("rr_grant0", 32'(seq[0]), 32'd0);
        check("rr_grant1", 32'(seq[1]), 32'd1);
        check("rr_grant2", 32'(seq[2]), 32'd0);
        check("rr_grant3", 32'(seq[3]), 32'd1);
        repeat (2) cycle();

        // Address latched at grant despite later input changes.
        fix_lat = 4; r_en[1] = 1'b1; addr[1] = 32'h40;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (mem_r_en) begin
                check("latch_addr", mem_addr, 32'h40);
                addr[1] = 32'h80;
            end
            if (p1_ready) begin seen = 1'b1; r_en[1] = 1'b0; end
        end
        check("latch_done", 32'(seen), 32'd1);
        repeat (2) cycle();

        // Reset in the middle of a port-0 write.
        fix_lat = 6; w_en[0] = 1'b1; addr[0] = 32'h20;
        repeat (2) cycle();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1; w_en[0] = 1'b0;
        cycle();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_w_en", 32'(mem_w_en), 32'd0);
        check("abort_r_en", 32'(mem_r_en), 32'd0);
        check("abort_grant", 32'(grant_id), 32'd1);
        cnt0 = 0;
        repeat (6) begin
            cycle();
            if (p0_ready) cnt0++;
        end
        check("abort_no_ready", 32'(cnt0), 32'd0);

        // Randomized traffic, spurious responses and occasional resets.
        fix_lat = 0; spur_pct = 10; use_fix_data = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            cycle();
            rst = 1'b0;
            for (int p = 0; p < 2; p++) begin
                rdy = (p == 0) ? p0_ready : p1_ready;
                if (pend[p] && rdy) begin
                    pend[p] = 1'b0;
                    if ($urandom_range(0, 1) == 0) begin
                        w_en[p] = 1'b0; r_en[p] = 1'b0;
                    end else begin
                        start_req(p);
                    end
                end else if (!pend[p] && $urandom_range(0, 99) < 30) begin
                    start_req(p);
                end
                if (pend[p] && $urandom_range(0, 99) < 15) begin
                    addr[p] = $urandom; wdata[p] = $urandom;
                end
            end
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
        end
        w_en = 2'b00; r_en = 2'b00; rst = 1'b0; spur_pct = 0;
        repeat (20) cycle();

        // Fixed priority instance: port 0 must monopolise the memory.
        f_w_en = 2'b11; f_addr[0] = 32'h0; f_addr[1] = 32'h4;
        f_wdata[0] = 32'h1111_1111; f_wdata[1] = 32'h2222_2222;
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (f_busy) check("fix_grant", 32'(f_grant_id), 32'd0);
            if (f_mem_w_en) check("fix_wdata", f_mem_wdata, 32'h1111_1111);
            if (f_p0_ready) cnt0++;
            if (f_p1_ready) cnt1++;
        end
        check("fix_p1_ready_count", 32'(cnt1), 32'd0);
        check("fix_p0_ready_many", 32'(cnt0 >= 10), 32'd1);
        f_w_en = 2'b10;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (f_p1_ready) seen = 1'b1;
        end
        check("fix_p1_alone", 32'(seen), 32'd1);
        f_w_en = 2'b00;
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
